// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory arbiter.
//   - FSM state codes (IDLE, ISSUE, WAIT, RESP)
//   - access owner codes (OWN_I = instruction fetch, OWN_D = data load/store)
package mem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: grant decision between the fetch and data requesters.
//   Data wins over instruction. With MEM_ARB_STARVE_GUARD_EN defined, a streak
//   counter lets a waiting fetch through after DSTREAK_MAX back-to-back data
//   grants; without it data has strict priority and there is no counter.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   idle            arbiter FSM is in IDLE (only time a grant is made)
//   i_req, d_req    request levels
//   grant           a grant is made this cycle
//   owner           winner (OWN_I / OWN_D), meaningful when grant=1
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int DSTREAK_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic i_req,
    input  logic d_req,
    output logic grant,
    output logic owner
);

    assign grant = idle & (i_req | d_req);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = (DSTREAK_MAX < 2) ? 1 : $clog2(DSTREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_LIMIT = SW'(DSTREAK_MAX);

    logic [SW-1:0] streak;
    logic          i_turn;

    // The counter never passes the limit: at the limit the fetch wins and it clears.
    assign i_turn = i_req & (streak == STREAK_LIMIT);
    assign owner  = (d_req & ~i_turn) ? OWN_D : OWN_I;

    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (idle) begin
            if (!i_req)
                streak <= '0;
            else if (owner == OWN_I)
                streak <= '0;
            else
                streak <= streak + 1'b1;
        end
    end
`else
    logic unused;

    assign owner  = d_req ? OWN_D : OWN_I;
    assign unused = &{1'b0, clk, rst, (DSTREAK_MAX > 0)};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between an
// instruction-fetch port and a data (load/store) port. One access per 4 cycles;
// ack is visible 3 cycles after the request is granted.
// Optional feature: MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard
// inside mem_arb_prio.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_req/i_addr/i_kill               fetch request, address, branch cancel
//   i_ack/i_rdata                     fetch completion pulse and word
//   d_req/d_we/d_addr/d_wdata         data request (we=1 store)
//   d_ack/d_rdata                     data completion pulse and load word
//   mem_en/mem_we/mem_addr/mem_wdata  memory command
//   mem_rdata                         memory read data (one cycle after mem_en)
//   busy                              FSM not in IDLE
//
// state | meaning
// IDLE  | arbitrate; latch winner's command
// ISSUE | drive memory command (mem_en=1)
// WAIT  | capture memory read data
// RESP  | raise owner's ack on the next edge
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 10,
    parameter int DW          = 32,
    parameter int DSTREAK_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_kill,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    logic [1:0]    state;
    logic          owner_q;
    logic          we_q;
    logic          killed;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] ibuf;
    logic          grant;
    logic          grant_owner;
    logic          fetch_cancel;

    mem_arb_prio #(
        .DSTREAK_MAX(DSTREAK_MAX)
    ) u_prio (
        .clk   (clk),
        .rst   (rst),
        .idle  (state == IDLE),
        .i_req (i_req),
        .d_req (d_req),
        .grant (grant),
        .owner (grant_owner)
    );

    // Gating with rst keeps a store from landing on the same edge that resets us.
    assign mem_en    = (state == ISSUE) & ~rst;
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != IDLE);

    assign fetch_cancel = killed | i_kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner_q <= OWN_I;
            we_q    <= 1'b0;
            killed  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ibuf    <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_q <= grant_owner;
                        killed  <= 1'b0;
                        if (grant_owner == OWN_D) begin
                            addr_q  <= d_addr;
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
                        end else begin
                            addr_q  <= i_addr;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (owner_q == OWN_I && i_kill)
                        killed <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (owner_q == OWN_D) begin
                        if (!we_q)
                            d_rdata <= mem_rdata;
                    end else begin
                        // Fetch data is staged so a kill arriving in RESP can
                        // still leave i_rdata untouched.
                        ibuf <= mem_rdata;
                        if (i_kill)
                            killed <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (owner_q == OWN_D) begin
                        d_ack <= 1'b1;
                    end else if (!fetch_cancel) begin
                        i_ack   <= 1'b1;
                        i_rdata <= ibuf;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_kill, i_ack;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_ack;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.AW(AW), .DW(DW), .DSTREAK_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int k);
        case (k)
            5:       return 32'h2801000a;
            6:       return 32'h12345678;
            30:      return 32'h0000AAAA;
            default: return 32'(k) * 32'h01010101;
        endcase
    endfunction

    // Synchronous single-port memory, filled on the first clock (rst is held then).
    logic [DW-1:0] mem [0:1023];
    bit            mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 1024; k++) mem[k] <= init_word(k);
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic          own;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] exp_irdata, exp_drdata;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Every ack pops the oldest expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (i_ack || d_ack)) begin
            if (i_ack && d_ack) begin
                check("dual_ack", 32'd1, 32'd0);
            end else if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_owner", 32'(d_ack), 32'(e.own));
                if (e.own == OWN_D) check("d_rdata", d_rdata, e.data);
                else                check("i_rdata", i_rdata, e.data);
            end
        end
    end

    task automatic push_exp(input logic own, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
        exp_t e;
        e.own = own;
        if (own == OWN_I) begin
            exp_irdata = ref_mem[a];
            e.data     = exp_irdata;
        end else if (we) begin
            ref_mem[a] = wd;
            e.data     = exp_drdata;
        end else begin
            exp_drdata = ref_mem[a];
            e.data     = exp_drdata;
        end
        sb.push_back(e);
    endtask

    // Single access with exact cycle-by-cycle timing checks.
    task automatic do_access(input logic own, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd);
        @(negedge clk);
        if (own == OWN_D) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = a;
        end
        push_exp(own, we, a, wd);
        @(negedge clk);
        check("issue_en", 32'(mem_en), 32'd1);
        check("issue_we", 32'(mem_we), 32'(we));
        check("issue_addr", 32'(mem_addr), 32'(a));
        check("issue_busy", 32'(busy), 32'd1);
        if (we) check("issue_wdata", mem_wdata, wd);
        @(negedge clk);
        check("wait_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        check("resp_noack", 32'(i_ack | d_ack), 32'd0);
        @(negedge clk);
        check("ack_latency", (own == OWN_D) ? 32'(d_ack) : 32'(i_ack), 32'd1);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        int acks;
        rst = 1'b1; i_req = 1'b0; i_addr = '0; i_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 1024; k++) ref_mem[k] = init_word(k);
        exp_irdata = '0;
        exp_drdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_acks", 32'(i_ack | d_ack), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;

        do_access(OWN_I, 1'b0, 10'd5, '0);
        do_access(OWN_D, 1'b1, 10'd20, 32'h1E);
        do_access(OWN_D, 1'b0, 10'd20, '0);

        // i_kill must not disturb a data access.
        i_kill = 1'b1;
        do_access(OWN_D, 1'b0, 10'd7, '0);
        i_kill = 1'b0;

        // Both requesters held: arbitration order.
        @(negedge clk);
        i_req = 1'b1; i_addr = 10'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20;
        for (int n = 0; n < 8; n++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            push_exp((n % 4 == 3) ? OWN_I : OWN_D, 1'b0, (n % 4 == 3) ? 10'd5 : 10'd20, '0);
`else
            push_exp(OWN_D, 1'b0, 10'd20, '0);
`endif
        end
        acks = 0;
        for (int c = 0; c < 60 && acks < 8; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) acks++;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("arb_ack_count", 32'(acks), 32'd8);

        // Fetch killed during WAIT.
        @(negedge clk);
        i_req = 1'b1; i_addr = 10'd6;
        @(negedge clk);
        i_req = 1'b0;
        check("kill_issue_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        i_kill = 1'b1;
        @(negedge clk);
        i_kill = 1'b0;
        check("kill_resp_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("kill_no_ack", 32'(i_ack), 32'd0);
        check("kill_idle", 32'(busy), 32'd0);
        check("kill_rdata_kept", i_rdata, exp_irdata);
        do_access(OWN_I, 1'b0, 10'd6, '0);

        // Reset during ISSUE of a store.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd30; d_wdata = 32'h55;
        @(negedge clk);
        check("rstst_issue_en", 32'(mem_en), 32'd1);
        rst = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        check("rstst_mem_en", 32'(mem_en), 32'd0);
        check("rstst_mem_we", 32'(mem_we), 32'd0);
        check("rstst_busy", 32'(busy), 32'd0);
        check("rstst_mem_addr", 32'(mem_addr), 32'd0);
        check("rstst_mem_wdata", mem_wdata, 32'd0);
        check("rstst_acks", 32'(i_ack | d_ack), 32'd0);
        check("rstst_d_rdata", d_rdata, 32'd0);
        check("rstst_i_rdata", i_rdata, 32'd0);
        rst = 1'b0;
        d_we = 1'b0;
        exp_irdata = '0;
        exp_drdata = '0;
        repeat (4) @(negedge clk);
        check("rstst_still_idle", 32'(busy), 32'd0);
        do_access(OWN_D, 1'b0, 10'd30, '0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-address width (1024-word memory).
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter DSTREAK_MAX, default 3, meaning consecutive data grants allowed while a fetch waits.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_req, input, 1 bit: instruction-fetch request (level).
REQ-007 SHALL have port i_addr, input, AW bits: fetch word address.
REQ-008 SHALL have port i_kill, input, 1 bit: taken-branch cancel of the in-flight fetch.
REQ-009 SHALL have port i_ack, output, 1 bit: one-cycle fetch-complete pulse.
REQ-010 SHALL have port i_rdata, output, DW bits: fetched word, valid with i_ack.
REQ-011 SHALL have port d_req, input, 1 bit: data (LW/SW) request (level).
REQ-012 SHALL have port d_we, input, 1 bit: 1 = store, 0 = load.
REQ-013 SHALL have port d_addr, input, AW bits: data word address.
REQ-014 SHALL have port d_wdata, input, DW bits: store data.
REQ-015 SHALL have port d_ack, output, 1 bit: one-cycle data-complete pulse.
REQ-016 SHALL have port d_rdata, output, DW bits: load data, valid with d_ack.
REQ-017 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, AW) and mem_wdata (output, DW): single-port memory command.
REQ-018 SHALL have port mem_rdata, input, DW bits: memory read data, valid one cycle after the mem_en cycle.
REQ-019 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; it arbitrates only in IDLE and stays in IDLE when no request is present.
REQ-021 In IDLE with any request, SHALL latch owner, addr, we and wdata, and enter ISSUE.
REQ-022 In ISSUE, SHALL drive mem_en=1, with mem_we, mem_addr and mem_wdata from the latched values; mem_en=0 in all other states.
REQ-023 In WAIT, SHALL register mem_rdata into the owner's rdata; a store SHALL leave rdata unchanged.
REQ-024 In RESP, SHALL pulse the owner's ack for exactly one cycle; the other ack SHALL stay 0.
REQ-025 Latency from request sampled in IDLE at edge E0 to ack visible SHALL be 3 cycles (ack high E3..E4); throughput SHALL be one access per 4 cycles.
REQ-026 Requesters SHALL hold req, addr, we and wdata stable until ack; a request still high in the IDLE cycle after RESP SHALL count as a new transaction.
REQ-027 Priority SHALL go to data over instruction when both requests are high.
REQ-028 A streak counter SHALL increment on each data grant made while i_req=1, and SHALL clear on an instruction grant or whenever i_req=0 in IDLE.
REQ-029 When the streak counter equals DSTREAK_MAX and both requests are high, the instruction request SHALL be granted.
REQ-030 If i_kill=1 in any cycle from grant through RESP of a fetch, SHALL suppress i_ack and leave i_rdata unchanged; the memory read still completes and the FSM timing is unchanged.
REQ-031 i_kill SHALL have no effect on data accesses or in IDLE.
REQ-032 A store SHALL never be cancelled once granted.

Reset
REQ-033 rst=1 at a clock edge SHALL force state IDLE, streak 0, i_ack, d_ack, mem_en, mem_we and busy to 0, and mem_addr, mem_wdata, i_rdata and d_rdata to 0.
REQ-034 Reset asserted mid-access SHALL abandon that access with no ack; a write is not issued if reset hits during ISSUE.

Configuration
REQ-035 Macro MEM_ARB_STARVE_GUARD_EN SHALL control the starvation guard: if defined, REQ-028/029 apply; if undefined, there is no streak counter and data has strict priority.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the FSM state encoding (IDLE, ISSUE, WAIT, RESP) and the owner encoding (OWN_I, OWN_D).
REQ-037 Sub-module mem_arb_prio SHALL contain the grant decision and streak counter; all other logic stays in mem_arbiter.

Verification
REQ-038 i_req=1, i_addr=5, mem word 5=0x2801000a -> mem_en in cycle 1, i_ack in cycle 3 with i_rdata=0x2801000a.
REQ-039 d_req=1, d_we=1, d_addr=20, d_wdata=0x1E -> mem_we=1, mem_addr=20 in ISSUE; d_ack in cycle 3; a subsequent load of 20 returns 0x1E.
REQ-040 i_req and d_req both held high continuously, DSTREAK_MAX=3 -> grant order D,D,D,I,D,D,D,I; with macro undefined, only D grants occur.
REQ-041 i_kill=1 during WAIT of a fetch -> no i_ack, i_rdata unchanged, FSM back in IDLE after RESP.
REQ-042 rst=1 during ISSUE of a store -> all outputs 0 next cycle, no ack, and a following load shows the old memory value.
